// File: rtl/char_buffer.sv
// char_buffer: character RAM for the text overlay (score, round, messages).
//
// Holds DEPTH 7-bit ASCII codes. Game control loads it one char per cycle over
// a valid/ready stream. The font/draw path reads it through char_xy with a
// 1-cycle registered latency. After reset, and whenever clear is pulsed, the
// block sweeps every cell to BLANK. Reads beyond DEPTH return BLANK.
//
// Ports:
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   clear      1-cycle request to fill all cells with BLANK
//   wr_valid   wr_char is valid
//   wr_ready   block accepts a char this cycle (depends on state only)
//   wr_char    ASCII char; bit 7 is discarded
//   wr_last    marks the current char as the last of a string
//   busy       clear sweep in progress
//   wr_ptr     cell that the next accepted char is written to
//   char_xy    read index
//   char_code  registered read data
module char_buffer #(
    parameter int         DEPTH  = 16,
    parameter int         ADDR_W = 8,
    parameter logic [6:0] BLANK  = 7'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_char,
    input  logic              wr_last,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] char_xy,
    output logic [6:0]        char_code
);

    localparam int                IDX_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [6:0]        ram [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [6:0]        wr_data;
    logic              accept;

    // Handshake is only honoured in READY, and a same-cycle clear wins.
    assign accept = (state == READY) && wr_valid && !clear;

    // Next state and the single RAM write port (sweep or stream).
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = idx;
        wr_data   = BLANK;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (!clear && idx == LAST)
                    state_nxt = READY;
            end
            READY: begin
                wr_ready = 1'b1;
                if (clear) begin
                    state_nxt = CLEAR;
                end else if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_ptr;
                    wr_data = wr_char[6:0];
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            idx    <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            // Sweep index: restarts on clear, runs only while sweeping.
            if (clear || state != CLEAR || idx == LAST)
                idx <= '0;
            else
                idx <= idx + 1'b1;
            if (state == READY && clear)
                wr_ptr <= '0;
            else if (accept)
                wr_ptr <= (wr_last || wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    // RAM has no reset; the sweep after reset initialises it.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Registered read; sees the pre-write contents on a same-cell collision.
    always_ff @(posedge clk) begin
        if (rst)
            char_code <= BLANK;
        else if ({1'b0, char_xy} < DEPTH_W)
            char_code <= ram[char_xy[IDX_W-1:0]];
        else
            char_code <= BLANK;
    end

endmodule
